avalon_len_limiter: RTL and testbench

AVALON_LEN_LIMITER -- requirements
Module: avalon_len_limiter

---
 rtl/avalon_len_limiter_if.sv | 16 +
 rtl/avalon_len_limiter.sv | 89 ++++++++
 tb/tb_avalon_len_limiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/avalon_len_limiter_if.sv
// Avalon-ST style streaming interface: data, valid/rdy handshake, sop/eop framing
// and an empty-symbol count on the last beat.
interface avalon_st_if #(
   parameter int DATA_W  = 32,
   parameter int EMPTY_W = 2
);
   logic [DATA_W-1:0]  data;
   logic               valid;
   logic               rdy;
   logic               sop;
   logic               eop;
   logic [EMPTY_W-1:0] empty;

   modport master (output data, valid, sop, eop, empty, input rdy);
   modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_len_limiter.sv
// Zero-latency packet length limiter: forwards at most MAX_LEN beats per packet,
// forcing eop on the last allowed beat and swallowing the rest of a long packet.
module avalon_len_limiter #(
   parameter int MAX_LEN = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   avalon_st_if.slave       in_msg,
   avalon_st_if.master      out_msg,
   output logic             pkt_truncated,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] trunc_count
);

   typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;

   state_t      state, state_nxt;
   logic [15:0] beat_cnt, beat_cnt_nxt;
   logic [16:0] cnt_inc;
   logic        in_rdy, acc, force_eop, eop_o, done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      in_rdy       = (state == DROP) ? 1'b1 : out_msg.rdy;
      acc          = in_msg.valid & in_rdy;
      // Count this beat would reach; a sop restarts the packet at 1.
      cnt_inc      = in_msg.sop ? 17'd1 : {1'b0, beat_cnt} + 17'd1;
      force_eop    = ((state == IDLE && in_msg.sop) || state == IN_PKT) &&
                     !in_msg.eop && (cnt_inc == 17'(MAX_LEN));
      eop_o        = in_msg.eop | force_eop;

      in_msg.rdy    = in_rdy;
      out_msg.data  = in_msg.data;
      out_msg.valid = in_msg.valid;
      out_msg.sop   = in_msg.sop;
      out_msg.eop   = eop_o;
      out_msg.empty = force_eop ? '0 : in_msg.empty;
      if (state == DROP) begin
         out_msg.valid = 1'b0;
         out_msg.sop   = 1'b0;
      end
      done = acc && (state != DROP) && eop_o;

      case (state)
         IDLE: begin
            if (acc && in_msg.sop) begin
               beat_cnt_nxt = 16'd1;
               if (force_eop)        state_nxt = DROP;
               else if (!in_msg.eop) state_nxt = IN_PKT;
            end
         end
         IN_PKT: begin
            if (acc) begin
               beat_cnt_nxt = cnt_inc[15:0];
               if (in_msg.eop)     state_nxt = IDLE;
               else if (force_eop) state_nxt = DROP;
            end
         end
         DROP: begin
            if (acc && in_msg.eop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt      <= '0;
         pkt_truncated <= 1'b0;
         pkt_count     <= '0;
         trunc_count   <= '0;
      end else begin
         beat_cnt      <= beat_cnt_nxt;
         pkt_truncated <= acc & force_eop;
         if (done && pkt_count != '1)
            pkt_count <= pkt_count + CNT_W'(1);
         if (acc && force_eop && trunc_count != '1)
            trunc_count <= trunc_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_avalon_len_limiter.sv
// Directed bench for avalon_len_limiter: three instances (MAX_LEN=4, MAX_LEN=1,
// MAX_LEN=4 with 2-bit counters) share one stimulus source selected by sel.
module tb_avalon_len_limiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] sel = 2'd0;
   logic       src_valid = 1'b0, src_sop = 1'b0, src_eop = 1'b0, src_ordy = 1'b1;
   logic [1:0] src_empty = 2'd0;
   logic [7:0] src_data = 8'd0;
   logic       tog_mode = 1'b0;

   avalon_st_if #(.DATA_W(8), .EMPTY_W(2)) i0 (), o0 (), i1 (), o1 (), i2 (), o2 ();
   logic       trunc0, trunc1, trunc2;
   logic [15:0] pc0, tc0, pc1, tc1;
   logic [1:0]  pc2, tc2;

   assign i0.valid = src_valid && sel == 2'd0;
   assign i1.valid = src_valid && sel == 2'd1;
   assign i2.valid = src_valid && sel == 2'd2;
   assign {i0.sop, i0.eop, i0.empty, i0.data} = {src_sop, src_eop, src_empty, src_data};
   assign {i1.sop, i1.eop, i1.empty, i1.data} = {src_sop, src_eop, src_empty, src_data};
   assign {i2.sop, i2.eop, i2.empty, i2.data} = {src_sop, src_eop, src_empty, src_data};
   assign o0.rdy = src_ordy;
   assign o1.rdy = src_ordy;
   assign o2.rdy = src_ordy;

   avalon_len_limiter #(.MAX_LEN(4), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .in_msg(i0), .out_msg(o0),
      .pkt_truncated(trunc0), .pkt_count(pc0), .trunc_count(tc0));
   avalon_len_limiter #(.MAX_LEN(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .in_msg(i1), .out_msg(o1),
      .pkt_truncated(trunc1), .pkt_count(pc1), .trunc_count(tc1));
   avalon_len_limiter #(.MAX_LEN(4), .CNT_W(2))  u2 (.clk(clk), .rst(rst), .in_msg(i2), .out_msg(o2),
      .pkt_truncated(trunc2), .pkt_count(pc2), .trunc_count(tc2));

   logic        obs_irdy, obs_v, obs_sop, obs_eop, obs_trunc;
   logic [1:0]  obs_emp;
   logic [7:0]  obs_data;
   logic [31:0] obs_pc, obs_tc;

   always_comb begin
      obs_irdy = i0.rdy; obs_v = o0.valid; obs_sop = o0.sop; obs_eop = o0.eop;
      obs_emp = o0.empty; obs_data = o0.data; obs_trunc = trunc0;
      obs_pc = 32'(pc0); obs_tc = 32'(tc0);
      case (sel)
         2'd1: begin
            obs_irdy = i1.rdy; obs_v = o1.valid; obs_sop = o1.sop; obs_eop = o1.eop;
            obs_emp = o1.empty; obs_data = o1.data; obs_trunc = trunc1;
            obs_pc = 32'(pc1); obs_tc = 32'(tc1);
         end
         2'd2: begin
            obs_irdy = i2.rdy; obs_v = o2.valid; obs_sop = o2.sop; obs_eop = o2.eop;
            obs_emp = o2.empty; obs_data = o2.data; obs_trunc = trunc2;
            obs_pc = 32'(pc2); obs_tc = 32'(tc2);
         end
         default: ;
      endcase
   end

   // Counts pkt_truncated cycles so a pulse longer than one cycle is visible.
   int pulses = 0;
   always @(negedge clk) if (rst && obs_trunc) pulses <= pulses + 1;

   int tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Values seen on out_msg in the cycle the beat was accepted.
   logic       r_v, r_sop, r_eop, r_ordy;
   logic [1:0] r_emp;
   logic [7:0] r_data;

   task automatic beat(input logic s, input logic e, input logic [1:0] em, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      src_valid = 1'b1; src_sop = s; src_eop = e; src_empty = em; src_data = d;
      if (tog_mode) src_ordy = ~src_ordy;
      #1;
      while (!obs_irdy && n < 20) begin
         @(negedge clk);
         if (tog_mode) src_ordy = ~src_ordy;
         #1;
         n++;
      end
      if (n >= 20) begin
         tests++; fails++;
         $display("FAIL accept_timeout data=%0h", d);
      end
      r_v = obs_v; r_sop = obs_sop; r_eop = obs_eop; r_emp = obs_emp;
      r_data = obs_data; r_ordy = src_ordy;
      @(posedge clk);
      #1;
      src_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; src_valid = 1'b0; src_ordy = 1'b1; tog_mode = 1'b0;
      #1;
      chk("rst_pkt_count", obs_pc, 0);
      chk("rst_trunc_count", obs_tc, 0);
      chk("rst_pulse", {31'd0, obs_trunc}, 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   int p0;
   logic [7:0] fwd [$];

   initial begin
      // Test A: 3-beat packet on MAX_LEN=4 passes untouched
      sel = 2'd0; do_reset(); p0 = pulses;
      beat(1, 0, 2'd0, 8'h10); chk("a_b1", {r_v, r_sop, r_eop, r_data}, {3'b110, 8'h10});
      beat(0, 0, 2'd0, 8'h11); chk("a_b2", {r_v, r_sop, r_eop, r_data}, {3'b100, 8'h11});
      beat(0, 1, 2'd1, 8'h12); chk("a_b3", {r_v, r_eop, r_emp, r_data}, {2'b11, 2'd1, 8'h12});
      chk("a_pkt_count", obs_pc, 1);
      chk("a_trunc_count", obs_tc, 0);
      chk("a_pulses", pulses - p0, 0);

      // Test B: 6-beat packet cut at beat 4
      do_reset(); p0 = pulses;
      beat(1, 0, 2'd1, 8'h20); chk("b_b1", {r_v, r_eop, r_emp, r_data}, {2'b10, 2'd1, 8'h20});
      beat(0, 0, 2'd1, 8'h21);
      beat(0, 0, 2'd1, 8'h22); chk("b_b3", {r_v, r_eop, r_emp, r_data}, {2'b10, 2'd1, 8'h22});
      beat(0, 0, 2'd1, 8'h23); chk("b_b4", {r_v, r_eop, r_emp, r_data}, {2'b11, 2'd0, 8'h23});
      chk("b_pulse_now", {31'd0, obs_trunc}, 1);
      beat(0, 0, 2'd0, 8'h24); chk("b_b5", {r_v, r_sop}, 2'b00);
      chk("b_pulse_gone", {31'd0, obs_trunc}, 0);
      beat(0, 1, 2'd2, 8'h25); chk("b_b6", {r_v, r_sop}, 2'b00);
      chk("b_pkt_count", obs_pc, 1);
      chk("b_trunc_count", obs_tc, 1);
      chk("b_pulses", pulses - p0, 1);

      // Test C: exactly MAX_LEN beats is not a truncation, back to IDLE
      do_reset(); p0 = pulses;
      beat(1, 0, 2'd0, 8'h30);
      beat(0, 0, 2'd0, 8'h31);
      beat(0, 0, 2'd0, 8'h32);
      beat(0, 1, 2'd2, 8'h33); chk("c_b4", {r_v, r_eop, r_emp, r_data}, {2'b11, 2'd2, 8'h33});
      chk("c_trunc_count", obs_tc, 0);
      chk("c_pkt_count", obs_pc, 1);
      beat(1, 0, 2'd0, 8'h34); chk("c_next_sop", {r_v, r_sop}, 2'b11);
      beat(0, 1, 2'd0, 8'h35);
      chk("c_pkt_count2", obs_pc, 2);
      chk("c_pulses", pulses - p0, 0);

      // Test D: out rdy toggling, then DROP consumes with out rdy low
      do_reset(); p0 = pulses; tog_mode = 1'b1;
      fwd.delete();
      beat(1, 0, 2'd0, 8'h40); if (r_v) fwd.push_back(r_data);
      beat(0, 0, 2'd0, 8'h41); if (r_v) fwd.push_back(r_data);
      beat(0, 0, 2'd0, 8'h42); if (r_v) fwd.push_back(r_data);
      beat(0, 0, 2'd0, 8'h43); if (r_v) fwd.push_back(r_data);
      chk("d_b4_eop", {31'd0, r_eop}, 1);
      chk("d_fwd_n", fwd.size(), 4);
      for (int i = 0; i < fwd.size() && i < 4; i++) chk("d_fwd_data", fwd[i], 32'h40 + i);
      tog_mode = 1'b0; src_ordy = 1'b0;
      beat(0, 0, 2'd0, 8'h44); chk("d_drop_b5", {r_v, r_ordy}, 2'b00);
      beat(0, 1, 2'd0, 8'h45); chk("d_drop_b6", {r_v, r_ordy}, 2'b00);
      src_ordy = 1'b1;
      chk("d_pkt_count", obs_pc, 1);
      chk("d_trunc_count", obs_tc, 1);
      chk("d_pulses", pulses - p0, 1);

      // Test E: MAX_LEN=1
      sel = 2'd1; do_reset(); p0 = pulses;
      beat(1, 1, 2'd3, 8'h50); chk("e_single", {r_v, r_sop, r_eop, r_emp}, {3'b111, 2'd3});
      beat(1, 0, 2'd1, 8'h51); chk("e_cut", {r_v, r_sop, r_eop, r_emp, r_data}, {3'b111, 2'd0, 8'h51});
      beat(0, 0, 2'd0, 8'h52); chk("e_drop1", {31'd0, r_v}, 0);
      beat(0, 1, 2'd0, 8'h53); chk("e_drop2", {31'd0, r_v}, 0);
      chk("e_pkt_count", obs_pc, 2);
      chk("e_trunc_count", obs_tc, 1);
      chk("e_pulses", pulses - p0, 1);

      // Test F: 2-bit counters saturate, async reset mid-packet
      sel = 2'd2; do_reset();
      for (int k = 0; k < 5; k++) begin
         beat(1, 1, 2'd0, 8'(8'h60 + k));
         if (k == 2) chk("f_pkt_count3", obs_pc, 3);
      end
      chk("f_pkt_sat", obs_pc, 3);
      beat(1, 0, 2'd0, 8'h70);
      for (int k = 1; k < 5; k++) beat(0, 0, 2'd0, 8'(8'h70 + k));
      beat(0, 1, 2'd0, 8'h75);
      chk("f_trunc_count", obs_tc, 1);
      chk("f_pkt_still_sat", obs_pc, 3);
      beat(1, 0, 2'd0, 8'h80);
      beat(0, 0, 2'd0, 8'h81);
      beat(0, 0, 2'd0, 8'h82);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      chk("f_rst_pkt_now", obs_pc, 0);
      chk("f_rst_trunc_now", obs_tc, 0);
      chk("f_rst_pulse_now", {31'd0, obs_trunc}, 0);
      @(negedge clk);
      rst = 1'b1;
      beat(0, 0, 2'd1, 8'h83); chk("f_post_rst_idle", {r_v, r_eop, r_emp, r_data}, {2'b10, 2'd1, 8'h83});
      beat(0, 1, 2'd0, 8'h84);
      chk("f_post_pkt_count", obs_pc, 1);
      chk("f_post_trunc_count", obs_tc, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
